// File: rtl/border_extend_par.sv
// Border extension engine: streams an EWxEH extended frame from a WIDTHxHEIGHT source RAM.
// Optional constant-border mode is compiled in with BORDER_EXTEND_CONST_EN.
module border_extend_par #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int BORDER = 19,
  parameter int PIX_W  = 8,
  parameter int RD_LAT = 1,
  localparam int EW     = WIDTH + 2*BORDER,
  localparam int EH     = HEIGHT + 2*BORDER,
  localparam int N      = EW*EH,
  localparam int SRC_AW = $clog2(WIDTH*HEIGHT),
  localparam int DST_AW = $clog2(N)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  const_val,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              dst_wr_en,
  output logic [DST_AW-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2((EW > EH ? EW : EH) + 1);
  localparam logic [CW-1:0]     X_LAST = CW'(EW-1);
  localparam logic [CW-1:0]     Y_LAST = CW'(EH-1);
  localparam logic [DST_AW-1:0] D_LAST = DST_AW'(N-1);
  localparam logic [SRC_AW-1:0] W_STEP = SRC_AW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DRAIN = 2'd2} state_t;

  // Extended -> source coordinate fold; gm: 0 reflect, 1 reflect-101, else replicate.
  // Modular CW-bit arithmetic is exact because every result lies in 0..n-1.
  function automatic logic [CW-1:0] f_map(input logic [CW-1:0] e, input int n,
                                          input logic [1:0] gm);
    logic [CW-1:0] lo, hi, s;
    lo = CW'(BORDER);
    hi = CW'(n + BORDER);
    s  = e - lo;
    if (e < lo) begin
      case (gm)
        2'd0:    s = CW'(BORDER-1) - e;
        2'd1:    s = lo - e;
        default: s = '0;
      endcase
    end else if (e >= hi) begin
      case (gm)
        2'd0:    s = CW'(2*n + BORDER - 1) - e;
        2'd1:    s = CW'(2*n + BORDER - 2) - e;
        default: s = CW'(n-1);
      endcase
    end
    return s;
  endfunction

  state_t r_state, w_nstate;

  logic [1:0]              r_gmode;
  logic [CW-1:0]           r_x, r_y;
  logic [SRC_AW-1:0]       r_rowbase;
  logic [DST_AW-1:0]       r_didx;
  logic                    r_src_rd_en;
  logic [SRC_AW-1:0]       r_src_addr;
  logic                    r_done;
  logic [RD_LAT:0]         r_vld_pipe;
  logic [RD_LAT:0][DST_AW-1:0] r_adr_pipe;

  logic              w_scan, w_accept, w_xend, w_yend, w_last_wr, w_cborder;
  logic [1:0]        w_gmode_in;
  logic [SRC_AW-1:0] w_base0;
  logic [CW-1:0]     w_sx, w_sy, w_sy_nxt;

`ifdef BORDER_EXTEND_CONST_EN
  logic                r_cmode;
  logic [PIX_W-1:0]    r_cval;
  logic [RD_LAT:0]     r_cst_pipe;
  logic                w_border;
`else
  logic                w_unused_cval;
  assign w_unused_cval = ^const_val;
`endif

  assign w_scan    = (r_state == S_SCAN);
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_xend    = (r_x == X_LAST);
  assign w_yend    = (r_y == Y_LAST);
  assign w_last_wr = r_vld_pipe[RD_LAT] && (r_adr_pipe[RD_LAT] == D_LAST);

  assign w_sx     = f_map(r_x, WIDTH, r_gmode);
  assign w_sy     = f_map(r_y, HEIGHT, r_gmode);
  assign w_sy_nxt = f_map(r_y + CW'(1), HEIGHT, r_gmode);

`ifdef BORDER_EXTEND_CONST_EN
  assign w_border  = (r_x < CW'(BORDER)) || (r_x >= CW'(WIDTH + BORDER)) ||
                     (r_y < CW'(BORDER)) || (r_y >= CW'(HEIGHT + BORDER));
  assign w_cborder = r_cmode && w_border;
`else
  assign w_cborder = 1'b0;
`endif

  // Constant mode borrows the reflect fold for its interior addresses.
  always_comb begin
    w_gmode_in = mode;
    if (mode == 2'd3) begin
`ifdef BORDER_EXTEND_CONST_EN
      w_gmode_in = 2'd0;
`else
      w_gmode_in = 2'd2;
`endif
    end
  end

  always_comb begin
    w_base0 = '0;
    case (w_gmode_in)
      2'd0:    w_base0 = SRC_AW'((BORDER-1)*WIDTH);
      2'd1:    w_base0 = SRC_AW'(BORDER*WIDTH);
      default: w_base0 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nstate = S_SCAN;
      S_SCAN:  if (w_xend && w_yend) w_nstate = S_DRAIN;
      S_DRAIN: if (w_last_wr) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Coordinate stage. Source row base steps by +/-WIDTH since the folded row
  // index moves by at most one between consecutive extended rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_didx    <= '0;
      r_rowbase <= '0;
      r_gmode   <= '0;
`ifdef BORDER_EXTEND_CONST_EN
      r_cmode   <= 1'b0;
      r_cval    <= '0;
`endif
    end else if (w_accept) begin
      r_x       <= '0;
      r_y       <= '0;
      r_didx    <= '0;
      r_rowbase <= w_base0;
      r_gmode   <= w_gmode_in;
`ifdef BORDER_EXTEND_CONST_EN
      r_cmode   <= (mode == 2'd3);
      r_cval    <= const_val;
`endif
    end else if (w_scan) begin
      r_didx <= r_didx + DST_AW'(1);
      if (w_xend) begin
        r_x <= '0;
        r_y <= r_y + CW'(1);
        if (w_sy_nxt > w_sy)      r_rowbase <= r_rowbase + W_STEP;
        else if (w_sy_nxt < w_sy) r_rowbase <= r_rowbase - W_STEP;
      end else begin
        r_x <= r_x + CW'(1);
      end
    end
  end

  // Read stage feeds a RD_LAT-deep shift register aligned with returning data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_rd_en <= 1'b0;
      r_src_addr  <= '0;
      r_vld_pipe  <= '0;
      r_adr_pipe  <= '0;
      r_done      <= 1'b0;
`ifdef BORDER_EXTEND_CONST_EN
      r_cst_pipe  <= '0;
`endif
    end else begin
      r_src_rd_en   <= w_scan && !w_cborder;
      r_src_addr    <= w_scan ? (r_rowbase + SRC_AW'(w_sx)) : '0;
      r_vld_pipe[0] <= w_scan;
      r_adr_pipe[0] <= w_scan ? r_didx : '0;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_adr_pipe[i] <= r_adr_pipe[i-1];
      end
`ifdef BORDER_EXTEND_CONST_EN
      r_cst_pipe[0] <= w_scan && w_cborder;
      for (int i = 1; i <= RD_LAT; i++) r_cst_pipe[i] <= r_cst_pipe[i-1];
`endif
      r_done <= (r_state == S_DRAIN) && w_last_wr;
    end
  end

  assign src_rd_en = r_src_rd_en;
  assign src_addr  = r_src_addr;
  assign dst_wr_en = r_vld_pipe[RD_LAT];
  assign dst_addr  = r_adr_pipe[RD_LAT];
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

`ifdef BORDER_EXTEND_CONST_EN
  assign dst_data = !r_vld_pipe[RD_LAT] ? '0 :
                    (r_cst_pipe[RD_LAT] ? r_cval : src_data);
`else
  assign dst_data = r_vld_pipe[RD_LAT] ? src_data : '0;
`endif

endmodule
